brcomp_iter: RTL

Parametrised, multi-cycle branch comparator for the execute stage. It latches two operands through a valid/ready handshake and compares them CHUNK bits per cycle, starting from the MSB. It stops early at the first differing chunk and returns equal/less flags for signed or unsigned branches through a second valid/ready handshake. It is the area-reduced successor of the single-cycle comparator, for wide-XLEN or low-area configurations, and supports pipeline flush.

---
 rtl/brcomp_iter_if.sv | 24 ++
 rtl/brcomp_iter.sv | 108 ++++++++++
 2 files changed

// File: rtl/brcomp_iter_if.sv
// rtl/brcomp_iter_if.sv - request/response handshake bundle for the iterative branch comparator
interface brcomp_iter_if #(
    parameter int unsigned XLEN = 32
);
    logic            req_valid_i;
    logic            req_ready_o;
    logic            br_unsigned_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic            resp_valid_o;
    logic            resp_ready_i;
    logic            br_equal_o;
    logic            br_less_o;

    modport master (
        output req_valid_i, br_unsigned_i, rs1_data_i, rs2_data_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, br_equal_o, br_less_o
    );

    modport slave (
        input  req_valid_i, br_unsigned_i, rs1_data_i, rs2_data_i, resp_ready_i,
        output req_ready_o, resp_valid_o, br_equal_o, br_less_o
    );
endinterface

// File: rtl/brcomp_iter.sv
// rtl/brcomp_iter.sv - multi-cycle MSB-first chunked branch comparator with early exit
module brcomp_iter #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    brcomp_iter_if.slave  bus
);
    localparam int unsigned   NCHUNK = XLEN / CHUNK;
    localparam int unsigned   KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] KLAST  = KW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic            uns_q, uns_d;
    logic [KW-1:0]   k_q, k_d;
    logic            eq_q, eq_d, lt_q, lt_d;

    logic [XLEN-1:0] a_sh, b_sh;
    logic [CHUNK-1:0] ca, cb;
    int unsigned     shamt;

    // Chunk k sits at the top after shifting left by k*CHUNK; signed mode flips the
    // sign bit of chunk 0 so an unsigned compare orders two's-complement values.
    always_comb begin
        shamt = CHUNK * 32'(k_q);
        a_sh  = a_q << shamt;
        b_sh  = b_q << shamt;
        ca    = a_sh[XLEN-1 -: CHUNK];
        cb    = b_sh[XLEN-1 -: CHUNK];
        if (k_q == '0 && !uns_q) begin
            ca[CHUNK-1] = ~ca[CHUNK-1];
            cb[CHUNK-1] = ~cb[CHUNK-1];
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        uns_d   = uns_q;
        k_d     = k_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        if (flush_i) begin
            state_d = IDLE;
            k_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        a_d     = bus.rs1_data_i;
                        b_d     = bus.rs2_data_i;
                        uns_d   = bus.br_unsigned_i;
                        k_d     = '0;
                        state_d = CMP;
                    end
                end
                CMP: begin
                    if (ca != cb) begin
                        eq_d    = 1'b0;
                        lt_d    = (ca < cb);
                        state_d = DONE;
                    end else if (k_q == KLAST) begin
                        eq_d    = 1'b1;
                        lt_d    = 1'b0;
                        state_d = DONE;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.resp_ready_i) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            uns_q   <= 1'b0;
            k_q     <= '0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            uns_q   <= uns_d;
            k_q     <= k_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
        end
    end

    assign bus.req_ready_o  = (state_q == IDLE) && !flush_i;
    assign bus.resp_valid_o = (state_q == DONE);
    assign bus.br_equal_o   = eq_q;
    assign bus.br_less_o    = lt_q;
endmodule
